serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Parametrised multi-cycle adder/subtractor, the sequential successor to the single-bit full adder.
//  Adds two WIDTH-bit operands DIGIT bits per clock, keeping the carry in a register between digits.
//  Uses a valid/ready handshake on both sides, so it can sit between operand producers and result consumers.
//  Trades latency for area in datapaths where a WIDTH-bit ripple adder is too wide.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; WIDTH % DIGIT == 0 is required (elaboration-time check)
//  DIGIT  4   bits processed per cycle; NDIG = WIDTH/DIGIT cycles per operation; DIGIT==WIDTH gives 1 cycle
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (ignored when sub=1)
//  sub        in   1      1: compute a - b as a + ~b + 1
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (rst_n==0 at a clk edge): state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; ovf=0;
//    count=0; carry=0. Reset aborts any operation in progress: the partial result is discarded, nothing is emitted.
//  - FSM states IDLE, RUN, DONE. in_ready = (state==IDLE), combinational from state only.
//  - IDLE: on in_valid&&in_ready, latch a into a_sr and (sub ? ~b : b) into b_sr;
//    carry <= sub ? 1 : cin; save sign bits a[WIDTH-1] and b_eff[WIDTH-1]; count <= 0; go to RUN.
//  - RUN, each cycle:
//    {c,d} = a_sr[DIGIT-1:0] + b_sr[DIGIT-1:0] + carry;
//    a_sr and b_sr shift right by DIGIT; the sum register shifts right by DIGIT with d in the top digit;
//    carry <= c; count++.
//    On count==NDIG-1 go to DONE, with cout = final c and out_valid=1.
//  - Latency: operands accepted at edge k -> out_valid=1 after edge k+NDIG.
//  - ovf = (a_sign==b_eff_sign) && (sum[WIDTH-1]!=a_sign); registered together with sum.
//  - DONE: sum/cout/ovf/out_valid stay stable until out_valid&&out_ready, then go to IDLE next cycle.
//    out_valid then drops to 0; sum/cout/ovf hold their last value.
//  - No same-cycle accept while in DONE: one operation in flight; maximum rate is one result per NDIG+2 cycles.
//    in_valid outside IDLE is ignored; no operand is queued.
//  - out_ready is ignored outside DONE. sum is not meaningful while in RUN; consumers qualify it with out_valid.
//  - count width is $clog2(NDIG) with a minimum of 1 bit. With NDIG==1, RUN lasts exactly one cycle.
//  - Arithmetic is unsigned modulo 2^WIDTH. {cout,sum} == a + (sub ? ~b+1 : b) + (sub ? 0 : cin)
//    with no truncation other than WIDTH+1 bits.
// STRUCTURE
//  - Shared package adder_pkg: state enum type (IDLE/RUN/DONE) and helper function ndig(WIDTH,DIGIT).
//  - One sub-module, digit_adder #(DIGIT): combinational DIGIT-bit ripple of full-adder cells;
//    ports (x, y, ci) -> (s, co). Instantiated once.
//  - Top level holds the FSM, the shift registers, the carry/sign registers and the output registers.
// TESTING (default WIDTH=16, DIGIT=4, NDIG=4, unless stated)
//  1. Reset and latency:
//     - rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
//     - Then a=16'h1234, b=16'h4321, cin=0 -> sum=16'h5555, cout=0, ovf=0; out_valid rises exactly 4 edges after accept.
//  2. Inter-digit carry:
//     - a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0.
//     - a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0, ovf=1.
//  3. Subtract:
//     - a=16'h0005, b=16'h0007, sub=1, cin=1 -> sum=16'hFFFE, cout=0, ovf=0.
//     - a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
//  4. Backpressure:
//     - Hold out_ready=0 for 5 cycles in DONE -> sum/cout/ovf/out_valid stable, in_ready=0.
//     - A pulse on in_valid during the hold is ignored; then out_ready=1 -> IDLE one cycle later.
//  5. Reset mid-op: rst_n=0 during RUN (count==2) -> IDLE, out_valid=0 next edge, and no result is emitted afterwards.
//  6. Exhaustive sweep: WIDTH=3, DIGIT=1, all a, b, cin, sub (256 cases) -> {cout,sum} and ovf match a reference model.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package adder_pkg;

  // Control states of the serial adder
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit cycles needed for one WIDTH-bit operation
  function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from full-adder cells.
//   x, y : DIGIT-bit addends
//   ci   : carry in
//   s    : DIGIT-bit sum
//   co   : carry out of the top cell
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  // One full-adder cell per bit
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock with the
// carry held in a register, valid/ready handshake on input and output.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake (in_ready combinational from state)
//   a, b, cin, sub        : operands, carry-in, subtract select (a + ~b + 1)
//   out_valid/out_ready   : result handshake
//   sum, cout, ovf        : result, carry out of MSB, signed overflow
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH % DIGIT != 0) begin : g_width_check
    $error("serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-1:0] b_eff;
  logic             carry;
  logic             a_sign, b_sign;
  logic [CW-1:0]    count;
  logic [DIGIT-1:0] d;
  logic             c;
  logic             accept;
  logic             last;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (count == CW'(NDIG - 1));
  assign b_eff    = sub ? ~b : b;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x  (a_sr[DIGIT-1:0]),
    .y  (b_sr[DIGIT-1:0]),
    .ci (carry),
    .s  (d),
    .co (c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)                 state_nxt = RUN;
      RUN:     if (last)                   state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Datapath: operand load, digit shifting, result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      carry     <= 1'b0;
      a_sign    <= 1'b0;
      b_sign    <= 1'b0;
      count     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr   <= a;
            b_sr   <= b_eff;
            carry  <= sub ? 1'b1 : cin;
            a_sign <= a[WIDTH-1];
            b_sign <= b_eff[WIDTH-1];
            count  <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          // New digit enters at the top; after NDIG shifts the LSB digit sits at the bottom
          sum   <= (sum >> DIGIT) | (WIDTH'(d) << (WIDTH - DIGIT));
          carry <= c;
          count <= count + CW'(1);
          if (last) begin
            cout      <= c;
            // d[DIGIT-1] is the final MSB of the result
            ovf       <= (a_sign == b_sign) && (d[DIGIT-1] != a_sign);
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp16_t;

  typedef struct packed {
    logic [2:0] sum;
    logic       cout;
    logic       ovf;
  } exp3_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit / 4-bit-digit instance
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  // 3-bit / 1-bit-digit instance for the exhaustive sweep
  logic        in_valid3, in_ready3, cin3, sub3, out_valid3, out_ready3, cout3, ovf3;
  logic [2:0]  a3, b3, sum3;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder #(.WIDTH(3), .DIGIT(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .cin(cin3), .sub(sub3), .out_valid(out_valid3), .out_ready(out_ready3),
    .sum(sum3), .cout(cout3), .ovf(ovf3)
  );

  exp16_t q16[$];
  exp3_t  q3[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned sum in WIDTH+1 bits, overflow from true signed range
  function automatic void model(input int w, input longint unsigned ma, input longint unsigned mb,
                                input bit mcin, input bit msub,
                                output longint unsigned s, output bit co, output bit ov);
    longint unsigned mask, total;
    longint          sa, sb, r, smax, smin;
    mask  = (64'd1 << w) - 64'd1;
    total = ma + (msub ? (~mb & mask) : mb) + (msub ? 64'd1 : 64'(mcin));
    s     = total & mask;
    co    = total[w];
    sa    = ma[w-1] ? longint'(ma) - (longint'(1) << w) : longint'(ma);
    sb    = mb[w-1] ? longint'(mb) - (longint'(1) << w) : longint'(mb);
    r     = msub ? sa - sb : sa + sb + longint'(mcin);
    smax  = (longint'(1) << (w - 1)) - 1;
    smin  = -(longint'(1) << (w - 1));
    ov    = (r > smax) || (r < smin);
  endfunction

  // Scoreboard monitors: compare at each output handshake
  exp16_t e16;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q16.size() == 0) check("unexpected_out16", 64'd1, 64'd0);
      else begin
        e16 = q16.pop_front();
        check("sum16", 64'(sum), 64'(e16.sum));
        check("cout16", 64'(cout), 64'(e16.cout));
        check("ovf16", 64'(ovf), 64'(e16.ovf));
      end
    end
  end

  exp3_t e3;
  always @(negedge clk) begin
    if (rst_n && out_valid3 && out_ready3) begin
      if (q3.size() == 0) check("unexpected_out3", 64'd1, 64'd0);
      else begin
        e3 = q3.pop_front();
        check("sum3", 64'(sum3), 64'(e3.sum));
        check("cout3", 64'(cout3), 64'(e3.cout));
        check("ovf3", 64'(ovf3), 64'(e3.ovf));
      end
    end
  end

  // Present operands and wait for the accept edge; optionally push expectation
  task automatic accept16(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                          input logic tsub, input bit push, input exp16_t exp);
    int guard = 0;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!in_ready) check("accept16_timeout", 64'd0, 64'd1);
    if (push) q16.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid16(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!out_valid) check("valid16_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle16();
    int guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!in_ready) check("idle16_timeout", 64'd0, 64'd1);
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                      input logic tsub, input exp16_t exp, input string tag);
    int lat;
    accept16(ta, tb, tcin, tsub, 1'b1, exp);
    wait_valid16(lat);
    check({tag, "_latency"}, 64'(lat), 64'd4);
    wait_idle16();
  endtask

  task automatic op3(input logic [2:0] ta, input logic [2:0] tb, input logic tcin, input logic tsub);
    longint unsigned s;
    bit co, ov;
    int guard = 0;
    int lat   = 0;
    model(3, 64'(ta), 64'(tb), tcin, tsub, s, co, ov);
    a3 = ta; b3 = tb; cin3 = tcin; sub3 = tsub; in_valid3 = 1'b1;
    while (!in_ready3 && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!in_ready3) check("accept3_timeout", 64'd0, 64'd1);
    q3.push_back('{sum: 3'(s), cout: co, ovf: ov});
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    while (!out_valid3 && lat < 50) begin @(posedge clk); #1; lat++; end
    check("latency3", 64'(lat), 64'd3);
    guard = 0;
    while (!in_ready3 && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!in_ready3) check("idle3_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid3 = 1'b0; out_ready3 = 1'b1; a3 = '0; b3 = '0; cin3 = 1'b0; sub3 = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add, latency, inter-digit carry, subtract
    op16(16'h1234, 16'h4321, 1'b0, 1'b0, '{sum: 16'h5555, cout: 1'b0, ovf: 1'b0}, "add_basic");
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0}, "add_carry");
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1}, "add_ovf");
    op16(16'h0005, 16'h0007, 1'b1, 1'b1, '{sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0}, "sub_neg");
    op16(16'h8000, 16'h0001, 1'b0, 1'b1, '{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1}, "sub_ovf");
    op16(16'h0F0F, 16'h00F1, 1'b1, 1'b0, '{sum: 16'h1001, cout: 1'b0, ovf: 1'b0}, "add_cin");

    // Backpressure: hold in DONE, ignored in_valid pulse
    out_ready = 1'b0;
    accept16(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, '{sum: 16'h3333, cout: 1'b0, ovf: 1'b0});
    wait_valid16(lat);
    check("bp_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_sum", 64'(sum), 64'h3333);
      check("bp_cout", 64'(cout), 64'd0);
      check("bp_ovf", 64'(ovf), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_hold_sum", 64'(sum), 64'h3333);
    repeat (10) @(posedge clk);
    #1;

    // Reset during RUN at count==2: nothing emitted
    accept16(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      check("midrst_no_output", 64'(out_valid), 64'd0);
    end
    op16(16'h0001, 16'h0002, 1'b1, 1'b0, '{sum: 16'h0004, cout: 1'b0, ovf: 1'b0}, "post_rst");

    // Exhaustive 3-bit sweep against the reference model
    for (int ia = 0; ia < 8; ia++)
      for (int ib = 0; ib < 8; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++)
            op3(3'(ia), 3'(ib), 1'(ic), 1'(is));

    repeat (5) @(posedge clk);
    #1;
    check("q16_drained", 64'(q16.size()), 64'd0);
    check("q3_drained", 64'(q3.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
